// File: rtl/downcounter_ctrl_if.sv
// Bundle between the pushbutton/counter environment and downcounter_ctrl.
// pb_* are single-cycle event pulses sampled on clk; all controller outputs are registered.
interface downcounter_ctrl_if;
   logic       pb_start;
   logic       pb_set;
   logic       pb_inc;
   logic       pb_rst;
   logic       count_zero;
   logic       en;
   logic       load;
   logic [3:0] initial_2;
   logic [3:0] initial_1;
   logic [3:0] initial_0;
   logic       set_mode;
   logic [1:0] cursor;
   logic [2:0] state_dbg;

   modport master (
      input  pb_start, pb_set, pb_inc, pb_rst, count_zero,
      output en, load, initial_2, initial_1, initial_0, set_mode, cursor, state_dbg
   );

   modport slave (
      output pb_start, pb_set, pb_inc, pb_rst, count_zero,
      input  en, load, initial_2, initial_1, initial_0, set_mode, cursor, state_dbg
   );
endinterface

// File: rtl/downcounter_ctrl.sv
// Set/run/pause controller for the M:SS down counter: owns preset digits,
// drives count enable and the one-cycle load strobe.
module downcounter_ctrl #(
   parameter logic [3:0] INIT_D2 = 4'd1,
   parameter logic [3:0] INIT_D1 = 4'd0,
   parameter logic [3:0] INIT_D0 = 4'd0
) (
   input logic                 clk,
   input logic                 rst_n,
   downcounter_ctrl_if.master  bus
);

   // state_dbg encoding: 0 IDLE, 1 SET, 2 RUN, 3 PAUSE, 4 DONE
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_RUN   = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] cursor_q, cursor_d;
   logic [3:0] d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
   logic       load_q, load_d;
   logic       en_q, set_mode_q;
   logic       first_q;
   logic       preset_zero;

   function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] max_v);
      return (v >= max_v) ? 4'd0 : v + 4'd1;
   endfunction

   assign preset_zero = (d2_q == 4'd0) && (d1_q == 4'd0) && (d0_q == 4'd0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cursor_q   <= 2'd0;
         d2_q       <= INIT_D2;
         d1_q       <= INIT_D1;
         d0_q       <= INIT_D0;
         load_q     <= 1'b0;
         en_q       <= 1'b0;
         set_mode_q <= 1'b0;
         first_q    <= 1'b1;
      end else begin
         state_q    <= state_d;
         cursor_q   <= cursor_d;
         d2_q       <= d2_d;
         d1_q       <= d1_d;
         d0_q       <= d0_d;
         load_q     <= load_d;
         en_q       <= (state_d == S_RUN);
         set_mode_q <= (state_d == S_SET);
         first_q    <= 1'b0;
      end
   end

   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      d2_d     = d2_q;
      d1_d     = d1_q;
      d0_d     = d0_q;
      load_d   = 1'b0;

      // The first edge after reset only issues the power-on load; pulses there are
      // dropped so that load can never overlap en or repeat back-to-back.
      if (first_q) begin
         load_d = 1'b1;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.pb_rst) begin
                  state_d = S_IDLE;
               end else if (bus.pb_start) begin
                  if (!preset_zero) state_d = S_RUN;
               end else if (bus.pb_set) begin
                  state_d  = S_SET;
                  cursor_d = 2'd2;
               end
            end
            S_SET: begin
               if (bus.pb_rst) begin
                  state_d = S_IDLE;
                  load_d  = 1'b1;
               end else if (bus.pb_set) begin
                  if (cursor_q == 2'd0) begin
                     state_d = S_IDLE;
                     load_d  = 1'b1;
                  end else begin
                     cursor_d = cursor_q - 2'd1;
                  end
               end else if (bus.pb_inc) begin
                  case (cursor_q)
                     2'd2:    d2_d = wrap_inc(d2_q, 4'd9);
                     2'd1:    d1_d = wrap_inc(d1_q, 4'd5);
                     2'd0:    d0_d = wrap_inc(d0_q, 4'd9);
                     default: d0_d = d0_q;
                  endcase
               end
            end
            S_RUN: begin
               if (bus.pb_rst) begin
                  state_d = S_IDLE;
                  load_d  = 1'b1;
               end else if (bus.count_zero) begin
                  state_d = S_DONE;
               end else if (bus.pb_start) begin
                  state_d = S_PAUSE;
               end
            end
            S_PAUSE: begin
               if (bus.pb_rst) begin
                  state_d = S_IDLE;
                  load_d  = 1'b1;
               end else if (bus.pb_start) begin
                  state_d = S_RUN;
               end
            end
            S_DONE: begin
               if (bus.pb_rst || bus.pb_start) begin
                  state_d = S_IDLE;
                  load_d  = 1'b1;
               end
            end
            default: begin
               state_d = S_IDLE;
               load_d  = 1'b1;
            end
         endcase
      end

      if (state_d != S_SET) cursor_d = 2'd0;
   end

   assign bus.en        = en_q;
   assign bus.load      = load_q;
   assign bus.initial_2 = d2_q;
   assign bus.initial_1 = d1_q;
   assign bus.initial_0 = d0_q;
   assign bus.set_mode  = set_mode_q;
   assign bus.cursor    = cursor_q;
   assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_downcounter_ctrl.sv
// Bench for downcounter_ctrl: vector table, hand sequences for reset/set corners,
// and randomized pulses against a digit-array reference model.
module tb_downcounter_ctrl;
   localparam int W = 20;
   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SET   = 3'd1;
   localparam logic [2:0] ST_RUN   = 3'd2;
   localparam logic [2:0] ST_PAUSE = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   downcounter_ctrl_if bus ();

   downcounter_ctrl #(
      .INIT_D2(4'd1),
      .INIT_D1(4'd0),
      .INIT_D0(4'd0)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   // scoreboard
   int n_checks = 0;
   int n_fail = 0;
   logic [W-1:0] exp_q[$];

   // reference model: digits as integers indexed 0=seconds,1=tens,2=minutes
   logic [2:0] m_mode;
   int         m_dig[3];
   int         m_cur;
   logic       m_load;
   logic       m_first;
   int         lim[3] = '{10, 6, 10};

   typedef struct {
      logic       s, st, i, r, cz;
      logic       en, load, sm;
      logic [1:0] cur;
      logic [3:0] d2, d1, d0;
      logic [2:0] state;
   } vec_t;
   vec_t tab[14];

   function automatic logic [W-1:0] actual_vec();
      return {bus.en, bus.load, bus.set_mode, bus.cursor,
              bus.initial_2, bus.initial_1, bus.initial_0, bus.state_dbg};
   endfunction

   function automatic logic [W-1:0] model_vec();
      logic [1:0] c;
      c = (m_mode == ST_SET) ? 2'(m_cur) : 2'd0;
      return {m_mode == ST_RUN, m_load, m_mode == ST_SET, c,
              4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0]), m_mode};
   endfunction

   task automatic model_reset();
      m_mode = ST_IDLE; m_dig[2] = 1; m_dig[1] = 0; m_dig[0] = 0;
      m_cur = 0; m_load = 1'b0; m_first = 1'b1;
   endtask

   task automatic go_idle_load();
      m_mode = ST_IDLE; m_load = 1'b1; m_cur = 0;
   endtask

   task automatic model_step(input logic s, input logic st, input logic i,
                             input logic r, input logic cz);
      m_load = 1'b0;
      if (m_first) begin
         m_first = 1'b0;
         m_load  = 1'b1;
      end else begin
         case (m_mode)
            ST_IDLE:
               if (!r) begin
                  if (s) begin
                     if (m_dig[0] + m_dig[1] + m_dig[2] != 0) m_mode = ST_RUN;
                  end else if (st) begin
                     m_mode = ST_SET; m_cur = 2;
                  end
               end
            ST_SET:
               if (r) go_idle_load();
               else if (st) begin
                  if (m_cur == 0) go_idle_load();
                  else m_cur = m_cur - 1;
               end else if (i) m_dig[m_cur] = (m_dig[m_cur] + 1) % lim[m_cur];
            ST_RUN:
               if (r) go_idle_load();
               else if (cz) m_mode = ST_DONE;
               else if (s) m_mode = ST_PAUSE;
            ST_PAUSE:
               if (r) go_idle_load();
               else if (s) m_mode = ST_RUN;
            default:
               if (r || s) go_idle_load();
         endcase
      end
   endtask

   task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_val(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // driver: called at posedge+1; drives pulses, lets one edge sample them, compares
   task automatic drive(input logic s, input logic st, input logic i,
                        input logic r, input logic cz);
      bus.pb_start = s; bus.pb_set = st; bus.pb_inc = i; bus.pb_rst = r; bus.count_zero = cz;
   endtask

   task automatic step(input string name, input logic s, input logic st, input logic i,
                       input logic r, input logic cz);
      drive(s, st, i, r, cz);
      model_step(s, st, i, r, cz);
      exp_q.push_back(model_vec());
      @(posedge clk);
      #1;
      check_vec(name, actual_vec(), exp_q.pop_front());
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      drive(0, 0, 0, 0, 0);
      model_reset();

      // reset state held across an edge
      @(posedge clk); #1;
      check_vec("reset_state", actual_vec(), {1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0, ST_IDLE});

      // power-on load: high only in the first cycle after release
      rst_n = 1'b1;
      step("por_cycle1", 0, 0, 0, 0, 0);
      check_val("por_load_hi", int'(bus.load), 1);
      step("por_cycle2", 0, 0, 0, 0, 0);
      check_val("por_load_lo", int'(bus.load), 0);

      // vector table, preset 1:00
      tab[0]  = '{1,0,0,0,0, 1,0,0,2'd0, 4'd1,4'd0,4'd0, ST_RUN};
      tab[1]  = '{1,0,0,0,0, 0,0,0,2'd0, 4'd1,4'd0,4'd0, ST_PAUSE};
      tab[2]  = '{1,0,0,0,0, 1,0,0,2'd0, 4'd1,4'd0,4'd0, ST_RUN};
      tab[3]  = '{0,0,0,0,1, 0,0,0,2'd0, 4'd1,4'd0,4'd0, ST_DONE};
      tab[4]  = '{1,0,0,0,0, 0,1,0,2'd0, 4'd1,4'd0,4'd0, ST_IDLE};
      tab[5]  = '{0,0,0,0,0, 0,0,0,2'd0, 4'd1,4'd0,4'd0, ST_IDLE};
      tab[6]  = '{1,0,0,0,0, 1,0,0,2'd0, 4'd1,4'd0,4'd0, ST_RUN};
      tab[7]  = '{1,0,0,1,0, 0,1,0,2'd0, 4'd1,4'd0,4'd0, ST_IDLE};
      tab[8]  = '{1,0,0,0,0, 1,0,0,2'd0, 4'd1,4'd0,4'd0, ST_RUN};
      tab[9]  = '{1,0,0,0,1, 0,0,0,2'd0, 4'd1,4'd0,4'd0, ST_DONE};
      tab[10] = '{0,0,0,1,0, 0,1,0,2'd0, 4'd1,4'd0,4'd0, ST_IDLE};
      tab[11] = '{0,1,0,0,0, 0,0,1,2'd2, 4'd1,4'd0,4'd0, ST_SET};
      tab[12] = '{0,0,1,0,0, 0,0,1,2'd2, 4'd2,4'd0,4'd0, ST_SET};
      tab[13] = '{0,0,1,1,0, 0,1,0,2'd0, 4'd2,4'd0,4'd0, ST_IDLE};
      for (int k = 0; k < 14; k++) begin
         drive(tab[k].s, tab[k].st, tab[k].i, tab[k].r, tab[k].cz);
         model_step(tab[k].s, tab[k].st, tab[k].i, tab[k].r, tab[k].cz);
         exp_q.push_back({tab[k].en, tab[k].load, tab[k].sm, tab[k].cur,
                          tab[k].d2, tab[k].d1, tab[k].d0, tab[k].state});
         @(posedge clk); #1;
         check_vec($sformatf("tab%0d", k), actual_vec(), exp_q.pop_front());
         drive(0, 0, 0, 0, 0);
      end

      // fresh reset, then edit preset 1/0/0 -> 3/1/2 (tens and seconds wrap)
      rst_n = 1'b0; #2; rst_n = 1'b1;
      model_reset();
      step("por2", 0, 0, 0, 0, 0);
      step("set_enter", 0, 1, 0, 0, 0);
      check_val("cursor_2", int'(bus.cursor), 2);
      for (int k = 0; k < 2; k++) step("inc_min", 0, 0, 1, 0, 0);
      step("set_c1", 0, 1, 0, 0, 0);
      check_val("cursor_1", int'(bus.cursor), 1);
      for (int k = 0; k < 7; k++) step("inc_tens", 0, 0, 1, 0, 0);
      step("set_c0", 0, 1, 0, 0, 0);
      check_val("cursor_0", int'(bus.cursor), 0);
      check_val("no_load_in_set", int'(bus.load), 0);
      for (int k = 0; k < 12; k++) step("inc_sec", 0, 0, 1, 0, 0);
      step("set_exit", 0, 1, 0, 0, 0);
      check_vec("exit_load_312", actual_vec(), {1'b0, 1'b1, 1'b0, 2'd0, 4'd3, 4'd1, 4'd2, ST_IDLE});
      step("after_exit", 0, 0, 0, 0, 0);
      check_val("load_single", int'(bus.load), 0);

      // asynchronous reset in RUN
      step("run_312", 1, 0, 0, 0, 0);
      check_val("run_en", int'(bus.en), 1);
      #3 rst_n = 1'b0;
      #1;
      check_vec("async_rst", actual_vec(), {1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 4'd0, 4'd0, ST_IDLE});
      @(posedge clk); #1;
      rst_n = 1'b1;
      model_reset();
      step("por3", 0, 0, 0, 0, 0);
      check_val("por3_load", int'(bus.load), 1);
      step("por3_b", 0, 0, 0, 0, 0);

      // preset 0:00 blocks start
      step("z_set", 0, 1, 0, 0, 0);
      for (int k = 0; k < 9; k++) step("z_inc", 0, 0, 1, 0, 0);
      step("z_set1", 0, 1, 0, 0, 0);
      step("z_set0", 0, 1, 0, 0, 0);
      step("z_exit", 0, 1, 0, 0, 0);
      check_vec("zero_preset", actual_vec(), {1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, ST_IDLE});
      step("z_start", 1, 0, 0, 0, 0);
      check_vec("zero_start_blocked", actual_vec(), {1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 4'd0, ST_IDLE});

      // randomized pulses against the model
      for (int n = 0; n < 800; n++) begin
         int ev;
         logic cz;
         ev = $urandom_range(0, 9);
         cz = ($urandom_range(0, 7) == 0);
         step($sformatf("rand%0d", n),
              (ev == 2 || ev == 3), (ev == 4 || ev == 5),
              (ev >= 6 && ev <= 8), (ev == 9), cz);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
